// File: rtl/pattern_gen.sv
// Replays AXI-stream pattern samples on dout at clk/(ckdiv+1), flagging underrun and completion.
// Optional feature macro: PATGEN_IDLE_LEVEL_EN (drives dout to idle_level outside replay).
module pattern_gen #(
    parameter int size    = 32,
    parameter int max_div = 32,
    parameter int saddr_w = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [size-1:0]            slave_tdata,
    input  logic                       slave_tvalid,
    input  logic                       slave_tlast,
    output logic                       slave_tready,
    input  logic [$clog2(max_div)-1:0] ckdiv,
    input  logic                       start,
    input  logic                       abort,
`ifdef PATGEN_IDLE_LEVEL_EN
    input  logic [size-1:0]            idle_level,
`endif
    output logic [size-1:0]            dout,
    output logic                       busy,
    output logic                       done,
    output logic                       underrun,
    output logic [saddr_w-1:0]         sample_count
);

    localparam int CKW = $clog2(max_div);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [size-1:0]    dout_q, dout_d;
    logic [CKW-1:0]     cnt_q, cnt_d;
    logic [CKW-1:0]     div_q, div_d;
    logic [saddr_w-1:0] count_q, count_d;
    logic               underrun_q, underrun_d;
    logic               last_seen_q, last_seen_d;
    logic               xfer;

    // A sample slot opens when the period counter has expired; abort closes it at once.
    assign slave_tready = (state_q == RUN) && (cnt_q == '0) && !last_seen_q && !abort;
    assign xfer         = slave_tvalid && slave_tready;

    always_comb begin
        state_d     = state_q;
        dout_d      = dout_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        count_d     = count_q;
        underrun_d  = underrun_q;
        last_seen_d = last_seen_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = RUN;
                        div_d       = ckdiv;
                        cnt_d       = '0;
                        underrun_d  = 1'b0;
                        count_d     = '0;
                        last_seen_d = 1'b0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        dout_d      = slave_tdata;
                        cnt_d       = div_q;
                        last_seen_d = slave_tlast;
                        if (!(&count_q)) begin
                            count_d = count_q + 1'b1;
                        end
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (last_seen_q) begin
                        state_d = DONE;
`ifdef PATGEN_IDLE_LEVEL_EN
                        dout_d  = idle_level;
`endif
                    end else if (!slave_tvalid) begin
                        underrun_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

`ifdef PATGEN_IDLE_LEVEL_EN
        // Outside replay the line rests at idle_level until the next run's first transfer.
        if (state_q == IDLE || state_q == DONE) begin
            dout_d = idle_level;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dout_q      <= '0;
            cnt_q       <= '0;
            div_q       <= '0;
            count_q     <= '0;
            underrun_q  <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            count_q     <= count_d;
            underrun_q  <= underrun_d;
            last_seen_q <= last_seen_d;
        end
    end

    assign dout         = dout_q;
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign underrun     = underrun_q;
    assign sample_count = count_q;

endmodule
